m_ext_ctrl: RTL and testbench
=============================

# m_ext_ctrl

Sequencing controller for the RV32M multiply/divide unit in the EX stage. It captures an M-type instruction's operands, holds the unit enable asserted until the unit responds, and stalls the pipeline while the unit is busy. It registers the result for a single-cycle hand-back and safely drains an in-flight operation when the pipeline flushes.

## Interface
- No parameters; widths fixed (XLEN 32, funct3 3, rd 5).
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_valid_i  in  1  M-op present in EX; held with stable fields while stall_o=1.
- funct3_i  in  3  M-op select (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
- rs1_i, rs2_i  in  32  operands.
- rd_i  in  5  destination register.
- flush_i  in  1  squash the EX-stage instruction (branch/exception).
- stall_o  out  1  hold IF/ID/EX.
- result_o  out  32  registered result.
- rd_o  out  5  registered destination.
- result_valid_o  out  1  one-cycle completion strobe.
- unit_en_o  out  1  enable to the M unit; drives its m_enable.
- unit_funct3_o  out  3  latched funct3.
- unit_a_o, unit_b_o  out  32  latched operands.
- unit_resp_i  in  1  unit done; unit_f_i valid this cycle.
- unit_f_i  in  32  unit result.

## Operation
- States: IDLE, BUSY, DONE, DRAIN, GAP.
- IDLE: if m_valid_i & !flush_i -> latch funct3/rs1/rs2/rd into unit_* regs, go BUSY. stall_o = m_valid_i & !flush_i (combinational).
- BUSY: unit_en_o=1, stall_o=1. unit_resp_i -> capture unit_f_i into result_o, go DONE. flush_i (without resp) -> DRAIN. If resp and flush coincide, flush wins: result discarded, go GAP.
- DONE: stall_o=0, unit_en_o=0, result_valid_o=1 unless flush_i. m_valid_i is ignored (same instruction still in EX). Next state IDLE.
- DRAIN: unit_en_o=1 with latched operands until unit_resp_i, result discarded. stall_o = m_valid_i. unit_resp_i -> GAP.
- GAP: unit_en_o=0, stall_o = m_valid_i. Next state IDLE. Guarantees the unit sees enable low at least one cycle between operations.
- The unit requires unit_en_o held high and operands/funct3 stable from start until unit_resp_i. The controller never changes unit_a/b/funct3 outside IDLE.
- No arithmetic is done here. Results, including divide-by-zero and overflow cases, pass through unchanged from unit_f_i.

## Timing
- Reset: state IDLE; stall_o=0, result_valid_o=0, unit_en_o=0, result_o=0, rd_o=0, unit_funct3_o=0, unit_a_o=0, unit_b_o=0; reuse cache invalid.
- Latency: unit response in cycle N after BUSY entry (N>=1) -> result_valid_o in cycle N+1. stall_o is high from the IDLE accept cycle through BUSY (N+1 cycles).
- Back-to-back M-ops: a second op is accepted in the IDLE cycle right after DONE, giving the unit one enable-low cycle.
- Reset mid-operation: immediate return to IDLE with all outputs zero. The unit sees enable drop and restarts cleanly.
- flush_i in IDLE: no accept. flush_i in DONE: result_valid_o suppressed.

## Configuration
- M_REUSE_EN defined: a cache holds funct3, a, b, and result of the last completed (non-flushed) op. An IDLE accept whose funct3/rs1/rs2 all match a valid cache entry skips BUSY and goes straight to DONE with the cached result. unit_en_o stays 0 and stall_o is high for the single accept cycle. The cache is invalidated on reset and overwritten at every DONE that takes its result from the unit.
- Undefined: no cache; every op goes through BUSY.

## Test plan
- mul, rs1=7, rs2=6, unit resp 3 cycles after BUSY entry -> stall_o high 4 cycles, then result_o=42, rd_o=rd_i, result_valid_o for 1 cycle, unit_en_o high exactly 3 cycles.
- div 100/7, flush_i asserted in the 2nd BUSY cycle, resp 30 cycles later -> stall_o drops on flush, unit_en_o stays high until resp, no result_valid_o, GAP lasts 1 cycle.
- mul 3*5 immediately followed by mulhu 0xFFFFFFFF*2 -> results 15 then 0x00000001, unit_en_o low for >=1 cycle between ops.
- Async rst pulse mid-BUSY on a div -> all outputs 0 within the same cycle, state IDLE. A subsequent mul 2*2 returns 4.
- With M_REUSE_EN: div 100/7 -> 14, then the same div again -> result 14 one cycle after accept, unit_en_o never asserted. rem 100/7 afterwards uses the unit and returns 2. Without the macro, the repeat div asserts unit_en_o.
- resp and flush_i in the same BUSY cycle -> no result_valid_o, result discarded, next op accepted after GAP.

Source files
------------

// File: rtl/m_ext_ctrl.sv
// m_ext_ctrl -- sequencing controller for the RV32M multiply/divide unit (EX stage).
//
// Captures an M-op's funct3/operands/rd on accept, holds unit_en_o high until
// the unit responds, stalls the pipeline meanwhile and hands the registered
// result back with a one-cycle strobe. A flush while the unit is working
// drains the operation (enable kept high until the response, result dropped).
//
// Optional feature: define M_REUSE_EN to add a one-entry result cache. An op
// whose funct3/rs1/rs2 match the last completed unit result skips the unit.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   m_valid_i           M-op present in EX (held stable while stall_o=1)
//   funct3_i/rs1_i/rs2_i/rd_i  op select, operands, destination
//   flush_i             squash the EX-stage instruction
//   stall_o             hold IF/ID/EX
//   result_o, rd_o      registered result and destination
//   result_valid_o      one-cycle completion strobe
//   unit_en_o           enable to the M unit
//   unit_funct3_o, unit_a_o, unit_b_o  latched op fields to the unit
//   unit_resp_i, unit_f_i  unit done strobe and its result
module m_ext_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o,
  output logic        result_valid_o,
  output logic        unit_en_o,
  output logic [2:0]  unit_funct3_o,
  output logic [31:0] unit_a_o,
  output logic [31:0] unit_b_o,
  input  logic        unit_resp_i,
  input  logic [31:0] unit_f_i
);

  typedef enum logic [2:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q, rd_d;
  logic        accept;
  logic        hit;
  logic [31:0] hit_res;

  assign accept = (state_q == S_IDLE) && m_valid_i && !flush_i;

`ifdef M_REUSE_EN
  logic        c_vld_q, c_vld_d;
  logic [2:0]  c_f3_q, c_f3_d;
  logic [31:0] c_a_q, c_a_d, c_b_q, c_b_d, c_res_q, c_res_d;
  // Distinguishes a DONE reached through the unit from one reached via a hit.
  logic        from_unit_q, from_unit_d;

  assign hit     = c_vld_q && (c_f3_q == funct3_i) && (c_a_q == rs1_i) && (c_b_q == rs2_i);
  assign hit_res = c_res_q;

  always_comb begin
    c_vld_d     = c_vld_q;
    c_f3_d      = c_f3_q;
    c_a_d       = c_a_q;
    c_b_d       = c_b_q;
    c_res_d     = c_res_q;
    from_unit_d = (state_q == S_BUSY);
    // Only a result actually handed back (not squashed in DONE) is remembered.
    if (state_q == S_DONE && from_unit_q && !flush_i) begin
      c_vld_d = 1'b1;
      c_f3_d  = funct3_q;
      c_a_d   = a_q;
      c_b_d   = b_q;
      c_res_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld_q     <= 1'b0;
      c_f3_q      <= '0;
      c_a_q       <= '0;
      c_b_q       <= '0;
      c_res_q     <= '0;
      from_unit_q <= 1'b0;
    end else begin
      c_vld_q     <= c_vld_d;
      c_f3_q      <= c_f3_d;
      c_a_q       <= c_a_d;
      c_b_q       <= c_b_d;
      c_res_q     <= c_res_d;
      from_unit_q <= from_unit_d;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Unit-facing fields only ever change here, so they stay stable
          // for the whole time the unit is enabled.
          funct3_d = funct3_i;
          a_d      = rs1_i;
          b_d      = rs2_i;
          rd_d     = rd_i;
          if (hit) begin
            result_d = hit_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // Flush wins over a coincident response: nothing left to drain.
        if (flush_i)          state_d = unit_resp_i ? S_GAP : S_DRAIN;
        else if (unit_resp_i) begin
          result_d = unit_f_i;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (unit_resp_i) state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    stall_o        = 1'b0;
    unit_en_o      = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      S_IDLE:  stall_o = accept;
      S_BUSY: begin
        stall_o   = 1'b1;
        unit_en_o = 1'b1;
      end
      S_DONE:  result_valid_o = !flush_i;
      S_DRAIN: begin
        stall_o   = m_valid_i;
        unit_en_o = 1'b1;
      end
      S_GAP:   stall_o = m_valid_i;
      default: stall_o = 1'b0;
    endcase
    // Keep stall low while reset is held even if the pipe still shows an op.
    if (rst) stall_o = 1'b0;
  end

  assign result_o      = result_q;
  assign rd_o          = rd_q;
  assign unit_funct3_o = funct3_q;
  assign unit_a_o      = a_q;
  assign unit_b_o      = b_q;

endmodule

// File: tb/tb_m_ext_ctrl.sv
module tb_m_ext_ctrl;

  logic        clk;
  logic        rst;
  logic        m_valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        result_valid_o;
  logic        unit_en_o;
  logic [2:0]  unit_funct3_o;
  logic [31:0] unit_a_o, unit_b_o;
  logic        unit_resp_i;
  logic [31:0] unit_f_i;

  m_ext_ctrl dut (
    .clk(clk), .rst(rst), .m_valid_i(m_valid_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .result_o(result_o), .rd_o(rd_o),
    .result_valid_o(result_valid_o), .unit_en_o(unit_en_o),
    .unit_funct3_o(unit_funct3_o), .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
    .unit_resp_i(unit_resp_i), .unit_f_i(unit_f_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   unit_lat;

  // Reference cache state: last op completed through the unit.
  bit          c_vld;
  logic [2:0]  c_f3;
  logic [31:0] c_a, c_b;

  // RV32M semantics from the ISA rules, computed with plain wide arithmetic.
  function automatic logic [31:0] ref_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] s1, s2;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    s1 = a;
    s2 = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return s1 / s2;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return s1 % s2;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Behavioural M unit: after unit_en_o rises, respond in the lat-th enabled cycle.
  initial begin
    int cnt, lat_cur;
    cnt = 0;
    lat_cur = 1;
    unit_resp_i = 1'b0;
    unit_f_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (unit_en_o) begin
        if (cnt == 0) lat_cur = unit_lat;
        cnt++;
      end else cnt = 0;
      unit_resp_i = unit_en_o && (cnt == lat_cur);
      unit_f_i = unit_resp_i ? ref_m(unit_funct3_o, unit_a_o, unit_b_o) : $urandom;
    end
  end

  // Monitor: scoreboard pop on result_valid_o plus unit protocol checks.
  initial begin
    logic en_p, resp_p;
    logic [2:0]  f3c;
    logic [31:0] ac, bc;
    exp_t e;
    en_p = 1'b0;
    resp_p = 1'b0;
    f3c = '0;
    ac = '0;
    bc = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (result_valid_o) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_result: got 0x%08h rd %0d, expected no result_valid_o (t=%0t)", result_o, rd_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk("result", result_o, e.res);
            chk("rd", 32'(rd_o), 32'(e.rd));
          end
        end
        if (resp_p) chk("en_low_after_resp", 32'(unit_en_o), 32'd0);
        if (unit_en_o && !en_p) begin
          f3c = unit_funct3_o;
          ac = unit_a_o;
          bc = unit_b_o;
        end
        if (unit_en_o && unit_resp_i) begin
          chk("unit_a_stable", unit_a_o, ac);
          chk("unit_b_stable", unit_b_o, bc);
          chk("unit_f3_stable", 32'(unit_funct3_o), 32'(f3c));
        end
      end
      en_p = unit_en_o;
      resp_p = unit_en_o && unit_resp_i;
    end
  end

  // Issue one op at posedge+1; hold it while stalled; optionally flush at cycle fl_at
  // (cycle 0 = accept cycle). Returns the number of unit_en_o cycles observed.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat, input int fl_at,
                        input bit from_idle, output int en_cnt);
    bit hit, flushed;
    int done_cyc, cyc, st_n, en_n, exp_st, exp_en;
    logic st_s;
    exp_t e;
`ifdef M_REUSE_EN
    hit = c_vld && (c_f3 == f3) && (c_a == a) && (c_b == b);
`else
    hit = 1'b0;
`endif
    done_cyc = hit ? 1 : lat + 1;
    flushed = (fl_at >= 0) && (fl_at <= done_cyc);
    if (!flushed) begin
      e.res = ref_m(f3, a, b);
      e.rd = rd;
      exp_q.push_back(e);
    end
    m_valid_i = 1'b1;
    funct3_i = f3;
    rs1_i = a;
    rs2_i = b;
    rd_i = rd;
    unit_lat = lat;
    cyc = 0;
    st_n = 0;
    en_n = 0;
    forever begin
      flush_i = (cyc == fl_at);
      @(negedge clk);
      st_s = stall_o;
      if (stall_o) st_n++;
      if (unit_en_o) en_n++;
      @(posedge clk);
      #1;
      if (flush_i) begin
        flush_i = 1'b0;
        m_valid_i = 1'b0;
      end
      cyc++;
      if (!st_s) break;
      if (cyc > 200) begin
        timeout_fail("op_complete");
        break;
      end
    end
    m_valid_i = 1'b0;
    flush_i = 1'b0;
    en_cnt = en_n;
    if (from_idle) begin
      if (!flushed) begin
        exp_st = done_cyc;
        exp_en = hit ? 0 : lat;
      end else begin
        exp_st = (fl_at == 0) ? 0 : ((fl_at + 1 < done_cyc) ? fl_at + 1 : done_cyc);
        exp_en = (hit || fl_at == 0) ? 0 : ((fl_at + 1 < lat) ? fl_at + 1 : lat);
      end
      chk("stall_cycles", 32'(st_n), 32'(exp_st));
      chk("unit_en_cycles", 32'(en_n), 32'(exp_en));
    end
    if (!flushed && !hit) begin
      c_vld = 1'b1;
      c_f3 = f3;
      c_a = a;
      c_b = b;
    end
  endtask

  // Wait out a draining op (and its GAP cycle); returns enable cycles seen.
  task automatic wait_drain(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!unit_en_o) begin
        done = 1'b1;
        break;
      end
      n++;
      @(posedge clk);
      #1;
    end
    if (!done) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int en_n, dn, lat, fl;
    logic [2:0]  f3;
    logic [31:0] a, b;
    n_cmp = 0;
    n_bad = 0;
    unit_lat = 1;
    c_vld = 1'b0;
    c_f3 = '0;
    c_a = '0;
    c_b = '0;
    rst = 1'b1;
    m_valid_i = 1'b0;
    funct3_i = '0;
    rs1_i = '0;
    rs2_i = '0;
    rd_i = '0;
    flush_i = 1'b0;

    // Reset state
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_valid", 32'(result_valid_o), 32'd0);
    chk("rst_en", 32'(unit_en_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);
    chk("rst_f3", 32'(unit_funct3_o), 32'd0);
    chk("rst_a", unit_a_o, 32'd0);
    chk("rst_b", unit_b_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // mul 7*6, response in 3rd BUSY cycle
    run_op(3'd0, 32'd7, 32'd6, 5'd5, 3, -1, 1'b1, en_n);

    // div 100/7 flushed in 2nd BUSY cycle, unit answers after 30 enabled cycles
    run_op(3'd4, 32'd100, 32'd7, 5'd6, 30, 2, 1'b1, en_n);
    wait_drain(dn);
    chk("drain_en_total", 32'(en_n + dn), 32'd30);

    // back-to-back mul 3*5 then mulhu 0xFFFFFFFF*2
    run_op(3'd0, 32'd3, 32'd5, 5'd7, 2, -1, 1'b1, en_n);
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd8, 2, -1, 1'b1, en_n);

    // async reset in the middle of a div
    m_valid_i = 1'b1;
    funct3_i = 3'd4;
    rs1_i = 32'd50;
    rs2_i = 32'd5;
    rd_i = 5'd9;
    unit_lat = 20;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("busy_before_rst", 32'(unit_en_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_en", 32'(unit_en_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_rd", 32'(rd_o), 32'd0);
    chk("midrst_a", unit_a_o, 32'd0);
    chk("midrst_b", unit_b_o, 32'd0);
    chk("midrst_f3", 32'(unit_funct3_o), 32'd0);
    c_vld = 1'b0;
    @(posedge clk);
    #1;
    m_valid_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op(3'd0, 32'd2, 32'd2, 5'd10, 2, -1, 1'b1, en_n);

    // repeat div (cache hit when reuse is built in), then rem via the unit
    run_op(3'd4, 32'd100, 32'd7, 5'd11, 4, -1, 1'b1, en_n);
    run_op(3'd4, 32'd100, 32'd7, 5'd12, 4, -1, 1'b1, en_n);
    run_op(3'd6, 32'd100, 32'd7, 5'd13, 3, -1, 1'b1, en_n);

    // response and flush in the same BUSY cycle, next op right behind
    run_op(3'd0, 32'd9, 32'd9, 5'd14, 3, 3, 1'b1, en_n);
    run_op(3'd0, 32'd11, 32'd11, 5'd15, 2, -1, 1'b1, en_n);

    // next op presented while a flushed op is still draining
    run_op(3'd5, 32'd1000, 32'd3, 5'd16, 10, 1, 1'b1, en_n);
    run_op(3'd0, 32'd4, 32'd4, 5'd17, 2, -1, 1'b0, en_n);

    // randomized ops, with repeats to exercise reuse
    f3 = '0;
    a = '0;
    b = '0;
    for (int i = 0; i < 60; i++) begin
      if (i == 0 || $urandom_range(0, 9) >= 3) begin
        f3 = 3'($urandom_range(0, 7));
        a = pick();
        b = pick();
      end
      lat = $urandom_range(1, 6);
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat + 1) : -1;
      run_op(f3, a, b, 5'($urandom_range(0, 31)), lat, fl, 1'b1, en_n);
      if (fl >= 0) wait_drain(dn);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
